mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU, and supports MTHI/MTLO writes. It sits beside the ALU in the execute stage. Busy is used by the hazard logic to stall MFHI/MFLO and any new mult/div op until the result is ready. Width is parametrised; one result bit is produced per cycle.

Parameters:
DATA_WIDTH, 32, operand and HI/LO register width (≥4).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Start  input  1  single-cycle request to begin the operation selected by Op
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  input  DATA_WIDTH  rs operand (multiplicand / dividend)
B  input  DATA_WIDTH  rt operand (multiplier / divisor)
HiWrite  input  1  MTHI: load WriteData into Hi
LoWrite  input  1  MTLO: load WriteData into Lo
WriteData  input  DATA_WIDTH  MTHI/MTLO data
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse: Hi/Lo hold a new result
DivByZero  output  1  one-cycle pulse together with Done for DIV/DIVU with B=0
Hi  output  DATA_WIDTH  HI register
Lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state IDLE; Hi=Lo=0; Busy=Done=DivByZero=0; internal accumulators cleared. A reset mid-operation aborts the operation and discards its result.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + Start=1: latch Op, the operand magnitudes (signed ops take two's-complement absolute value), the result signs and the iteration counter=DATA_WIDTH; go to CALC.
  - Exception: DIV/DIVU with B=0 goes straight to DONE. At that edge Hi=A and Lo=all-ones, and DivByZero pulses in the DONE cycle.
- CALC: one iteration per edge; the counter decrements; after DATA_WIDTH iterations go to FIX.
  - Multiply: shift-add into a 2×DATA_WIDTH product.
  - Divide: restoring division producing quotient and remainder magnitudes.
- FIX: apply sign correction and load Hi/Lo, then go to DONE.
  - MULT: negate the 2W product if the signs differ; Hi=upper W bits, Lo=lower W bits.
  - DIV: Lo=quotient, negated if sign(A)≠sign(B); Hi=remainder, carrying the sign of A.
  - Unsigned ops: no correction.
  - Most-negative/−1 wraps: Lo=most-negative, Hi=0.
- DONE: Done=1 for exactly this cycle, then IDLE. A Start in DONE is accepted (back-to-back operation).
- Busy=1 in CALC and FIX, 0 otherwise.
- Latency: with the edge that samples Start counted as edge 0, Hi/Lo update at edge DATA_WIDTH+1 and Done is high after that edge (33 edges for W=32). Divide-by-zero: update at edge 0, Done after edge 0.
- Start while Busy: ignored, no state change.
- HiWrite/LoWrite:
  - Honoured in IDLE and DONE only, at the next edge; they may be asserted together.
  - Ignored while Busy.
  - Start asserted in the same cycle wins and the write is dropped.
- Hi/Lo hold their values except on a FIX load, a divide-by-zero load, or an MTHI/MTLO write.

Optional Feature:
Macro MDU_EARLY_TERM_EN.
- Defined:
  - Multiply leaves CALC early once the remaining unshifted multiplier bits are all zero, with a minimum of 1 CALC cycle. The product is aligned by the remaining shift in FIX, so results are identical to the fixed-latency version.
  - Latency = (index of the multiplier's highest set bit + 1) + 1 edges, or 1 + 1 if the multiplier is zero.
  - Divide latency is unchanged.
- Undefined: fixed DATA_WIDTH-iteration CALC for all ops.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, Start 1 cycle → Busy high; Hi=0xFFFFFFFE, Lo=0x00000001; Done pulses once, 33 edges after the Start edge.
- MULT A=0xFFFFFFFD (−3), B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. With MDU_EARLY_TERM_EN: same values, Done after 4 edges.
- DIV A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then back-to-back Start in the DONE cycle: DIVU A=100, B=7 → Lo=14, Hi=2.
- DIV A=0x00001234, B=0 → after edge 0: DivByZero=Done=1 for one cycle, Hi=0x00001234, Lo=0xFFFFFFFF, Busy never asserted.
- MULTU 5×6 started, reset driven low at CALC iteration 10 → Busy=Done=0 and Hi=Lo=0 immediately. After release, MULTU 5×6 → Lo=30, Hi=0.
- IDLE: HiWrite=1, WriteData=0xCAFEBABE → Hi=0xCAFEBABE, Lo unchanged. During Busy: LoWrite=1 with 0x11111111 and a second Start → both ignored; the original result lands unchanged.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// HI/LO multiply/divide unit bus: request, MTHI/MTLO writes and result/status signals.
interface mult_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  HiWrite;
  logic                  LoWrite;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Busy;
  logic                  Done;
  logic                  DivByZero;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite, WriteData,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite, WriteData,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit, one result bit per cycle.
// Optional macro MDU_EARLY_TERM_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          stateQ, stateD;
  logic [CW-1:0]   countQ, countD;
  logic            isDivQ, isDivD, negResQ, negResD, negRemQ, negRemD;
  logic [2*W-1:0]  accQ, accD;
  logic [W-1:0]    bQ, bD, hiQ, hiD, loQ, loD;
  logic            dbzQ, dbzD;

  logic            startGo, opDiv, opSigned, divZero, lastIter, earlyExit;
  logic [W-1:0]    absA, absB, quoFix, remFix;
  logic [W:0]      mulSum, divDiff;
  logic [2*W-1:0]  mulStep, divStep, prodMag, prodFix;

  assign startGo  = bus.Start && (stateQ == StIdle || stateQ == StDone);
  assign opDiv    = bus.Op[1];
  assign opSigned = ~bus.Op[0];
  assign divZero  = opDiv && (bus.B == '0);
  assign absA     = (opSigned && bus.A[W-1]) ? -bus.A : bus.A;
  assign absB     = (opSigned && bus.B[W-1]) ? -bus.B : bus.B;

`ifdef MDU_EARLY_TERM_EN
  logic [W-1:0] mplierQ, mplierD;

  // Shadow of the not-yet-consumed multiplier bits; the low half of accQ mixes in product bits.
  always_comb begin
    mplierD = mplierQ;
    if (startGo) mplierD = absB;
    else if (stateQ == StCalc) mplierD = mplierQ >> 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mplierQ <= '0;
    else        mplierQ <= mplierD;
  end

  assign earlyExit = !isDivQ && ((mplierQ >> 1) == '0);
  assign prodMag   = accQ >> countQ;
`else
  assign earlyExit = 1'b0;
  assign prodMag   = accQ;
`endif

  assign lastIter = (countQ == CW'(1)) || earlyExit;

  always_comb begin
    mulSum  = {1'b0, accQ[2*W-1:W]} + (accQ[0] ? {1'b0, bQ} : '0);
    mulStep = {mulSum, accQ[W-1:1]};
    // Trial subtract of the shifted partial remainder (W+1 bits) against the divisor.
    divDiff = accQ[2*W-1:W-1] - {1'b0, bQ};
    divStep = divDiff[W] ? {accQ[2*W-2:0], 1'b0} : {divDiff[W-1:0], accQ[W-2:0], 1'b1};
    prodFix = negResQ ? -prodMag : prodMag;
    quoFix  = negResQ ? -accQ[W-1:0] : accQ[W-1:0];
    remFix  = negRemQ ? -accQ[2*W-1:W] : accQ[2*W-1:W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= StIdle;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle, StDone: begin
        stateD = StIdle;
        if (startGo) stateD = divZero ? StDone : StCalc;
      end
      StCalc:  if (lastIter) stateD = StFix;
      StFix:   stateD = StDone;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.Busy      = (stateQ == StCalc) || (stateQ == StFix);
    bus.Done      = (stateQ == StDone);
    bus.DivByZero = dbzQ;
    bus.Hi        = hiQ;
    bus.Lo        = loQ;
  end

  always_comb begin
    accD    = accQ;
    bD      = bQ;
    countD  = countQ;
    isDivD  = isDivQ;
    negResD = negResQ;
    negRemD = negRemQ;
    hiD     = hiQ;
    loD     = loQ;
    dbzD    = 1'b0;
    unique case (stateQ)
      StIdle, StDone: begin
        if (startGo) begin
          isDivD  = opDiv;
          negResD = opSigned && (bus.A[W-1] ^ bus.B[W-1]);
          negRemD = opSigned && bus.A[W-1];
          countD  = CW'(W);
          accD    = {{W{1'b0}}, opDiv ? absA : absB};
          bD      = opDiv ? absB : absA;
          if (divZero) begin
            hiD  = bus.A;
            loD  = '1;
            dbzD = 1'b1;
          end
        end else begin
          if (bus.HiWrite) hiD = bus.WriteData;
          if (bus.LoWrite) loD = bus.WriteData;
        end
      end
      StCalc: begin
        accD   = isDivQ ? divStep : mulStep;
        countD = countQ - CW'(1);
      end
      StFix: begin
        if (isDivQ) begin
          hiD = remFix;
          loD = quoFix;
        end else begin
          {hiD, loD} = prodFix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accQ    <= '0;
      bQ      <= '0;
      countQ  <= '0;
      isDivQ  <= 1'b0;
      negResQ <= 1'b0;
      negRemQ <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
      dbzQ    <= 1'b0;
    end else begin
      accQ    <= accD;
      bQ      <= bD;
      countQ  <= countD;
      isDivQ  <= isDivD;
      negResQ <= negResD;
      negRemQ <= negRemD;
      hiQ     <= hiD;
      loQ     <= loD;
      dbzQ    <= dbzD;
    end
  end
endmodule
